eth_rx_frame_fifo: RTL

Store-and-forward receive frame buffer sitting directly downstream of the 1G MAC receive path, in the `rx_clk` domain. It accepts the MAC's byte-wide receive AXI stream, which has no backpressure, and buffers each frame completely. It releases only whole frames that fit and that the MAC marked good, on a backpressured AXI stream towards the packet-processing logic. Overflowing frames, and bad frames (when configured), are discarded atomically.

---
 rtl/eth_rx_frame_fifo.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward receive frame buffer for the 1G MAC.
// Takes the MAC's byte stream (no backpressure), buffers whole frames and
// releases only complete, fitting, good frames on a backpressured stream.
// Optional feature macro: ETH_RX_FIFO_STATS_EN builds the saturating
// good/drop frame counters; without it both counter ports are tied to 0.
module eth_rx_frame_fifo #(
  parameter int DEPTH          = 4096,
  parameter bit DROP_BAD_FRAME = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        status_overflow,
  output logic        status_bad_frame,
  output logic        status_good_frame,
  output logic [15:0] stat_good_count,
  output logic [15:0] stat_drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry layout: {tuser on last beat, tlast, tdata}
  logic [9:0]    mem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] wrCommit_q, wrCommit_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          dropFlag_q, dropFlag_d;
  logic          ovfPulse_q, ovfPulse_d;
  logic          badPulse_q, badPulse_d;
  logic          goodPulse_q, goodPulse_d;
  logic          outValid_q, outValid_d;
  logic [9:0]    outWord_q, outWord_d;
  logic          memWrite;
  logic          full;
  logic          empty;
  logic          load;

  assign full  = (wrPtr_q - rdPtr_q) == PW'(DEPTH);
  assign empty = (rdPtr_q == wrCommit_q);
  assign load  = (!outValid_q || m_axis_tready) && !empty;

  // Write side: accept beats, then commit or rewind the frame on its last beat
  always_comb begin
    wrPtr_d     = wrPtr_q;
    wrCommit_d  = wrCommit_q;
    dropFlag_d  = dropFlag_q;
    ovfPulse_d  = 1'b0;
    badPulse_d  = 1'b0;
    goodPulse_d = 1'b0;
    memWrite    = 1'b0;
    if (s_axis_tvalid) begin
      if (!dropFlag_q && !full) begin
        memWrite = 1'b1;
        wrPtr_d  = wrPtr_q + PW'(1);
      end
      if (s_axis_tlast) begin
        dropFlag_d = 1'b0;
        if (dropFlag_q || full) begin
          wrPtr_d    = wrCommit_q;
          ovfPulse_d = 1'b1;
        end else if (s_axis_tuser && DROP_BAD_FRAME) begin
          wrPtr_d    = wrCommit_q;
          badPulse_d = 1'b1;
        end else begin
          wrCommit_d  = wrPtr_q + PW'(1);
          goodPulse_d = 1'b1;
          badPulse_d  = s_axis_tuser;
        end
      end else if (!dropFlag_q && full) begin
        dropFlag_d = 1'b1;
        wrPtr_d    = wrCommit_q;
      end
    end
  end

  // Read side: single output register refilled whenever it is free or consumed
  always_comb begin
    rdPtr_d    = rdPtr_q;
    outValid_d = outValid_q;
    outWord_d  = outWord_q;
    if (load) begin
      rdPtr_d    = rdPtr_q + PW'(1);
      outValid_d = 1'b1;
      outWord_d  = mem[rdPtr_q[AW-1:0]];
    end else if (m_axis_tready) begin
      outValid_d = 1'b0;
    end
  end

  // Frame storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[wrPtr_q[AW-1:0]] <= {s_axis_tuser & s_axis_tlast, s_axis_tlast, s_axis_tdata};
    end
  end

  // Pointer, drop flag, status pulse and output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q     <= '0;
      wrCommit_q  <= '0;
      rdPtr_q     <= '0;
      dropFlag_q  <= 1'b0;
      ovfPulse_q  <= 1'b0;
      badPulse_q  <= 1'b0;
      goodPulse_q <= 1'b0;
      outValid_q  <= 1'b0;
      outWord_q   <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      wrCommit_q  <= wrCommit_d;
      rdPtr_q     <= rdPtr_d;
      dropFlag_q  <= dropFlag_d;
      ovfPulse_q  <= ovfPulse_d;
      badPulse_q  <= badPulse_d;
      goodPulse_q <= goodPulse_d;
      outValid_q  <= outValid_d;
      outWord_q   <= outWord_d;
    end
  end

  assign m_axis_tvalid     = outValid_q;
  assign m_axis_tdata      = outWord_q[7:0];
  assign m_axis_tlast      = outWord_q[8];
  assign m_axis_tuser      = DROP_BAD_FRAME ? 1'b0 : outWord_q[9];
  assign status_overflow   = ovfPulse_q;
  assign status_bad_frame  = badPulse_q;
  assign status_good_frame = goodPulse_q;

`ifdef ETH_RX_FIFO_STATS_EN
  logic [15:0] goodCnt_q;
  logic [15:0] dropCnt_q;
  logic        dropEvent;

  // A frame is dropped on overflow, or when flagged bad and not committed
  assign dropEvent = ovfPulse_d || (badPulse_d && !goodPulse_d);

  // Saturating frame counters, updated on the edge that resolves the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      goodCnt_q <= '0;
      dropCnt_q <= '0;
    end else begin
      if (goodPulse_d && (goodCnt_q != 16'hFFFF)) begin
        goodCnt_q <= goodCnt_q + 16'd1;
      end
      if (dropEvent && (dropCnt_q != 16'hFFFF)) begin
        dropCnt_q <= dropCnt_q + 16'd1;
      end
    end
  end

  assign stat_good_count = goodCnt_q;
  assign stat_drop_count = dropCnt_q;
`else
  assign stat_good_count = '0;
  assign stat_drop_count = '0;
`endif

endmodule
